// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch front end for an 8-bit byte-coded core.
//
// The unit walks program memory one byte per cycle. An opcode with bit7 clear
// is a one-byte instruction. An opcode with bit7 set is followed by one operand
// byte. Each fetched instruction is held on the ir_* outputs until the execute
// stage accepts it. A redirect from execute reloads the PC and drops any
// instruction that is only partly fetched.
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   rom_adrs  [7:0]  program-memory address, driven straight from the PC
//   rom_q     [7:0]  program-memory data, combinational from rom_adrs
//   ir_valid         instruction present on ir_* (asserted only in HOLD)
//   ir_ready         execute accepts the presented instruction
//   ir_op     [7:0]  opcode byte
//   ir_operand[7:0]  operand byte, 8'h00 for one-byte instructions
//   ir_pc     [7:0]  address of the opcode byte
//   redirect         execute requests a jump
//   redirect_target  new PC, used when redirect=1
//   fetch_count[15:0] number of accepted instructions, wraps at 16 bits
// -----------------------------------------------------------------------------
module fetch_unit (
   input  logic        clock,
   input  logic        reset_n,
   output logic [7:0]  rom_adrs,
   input  logic [7:0]  rom_q,
   output logic        ir_valid,
   input  logic        ir_ready,
   output logic [7:0]  ir_op,
   output logic [7:0]  ir_operand,
   output logic [7:0]  ir_pc,
   input  logic        redirect,
   input  logic [7:0]  redirect_target,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {S_OP, S_ARG, S_HOLD} state_t;

   state_t      state, state_nxt;
   logic [7:0]  pc, pc_nxt;
   logic [7:0]  op_nxt, operand_nxt, ir_pc_nxt;
   logic [15:0] cnt_nxt;
   logic        accept;

   assign rom_adrs = pc;
   assign ir_valid = (state == S_HOLD);
   assign accept   = (state == S_HOLD) && ir_ready;

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      op_nxt      = ir_op;
      operand_nxt = ir_operand;
      ir_pc_nxt   = ir_pc;
      cnt_nxt     = fetch_count;

      // An instruction accepted in the same cycle as a redirect still counts.
      if (accept)
         cnt_nxt = fetch_count + 16'd1;

      if (redirect) begin
         // Partial fetches are dropped. The ir_* registers keep their old
         // contents, but nothing is presented until a new fetch completes.
         pc_nxt    = redirect_target;
         state_nxt = S_OP;
      end else begin
         case (state)
            S_OP: begin
               op_nxt    = rom_q;
               ir_pc_nxt = pc;
               pc_nxt    = pc + 8'd1;           // wraps FF -> 00
               if (rom_q[7]) begin
                  state_nxt = S_ARG;
               end else begin
                  operand_nxt = 8'h00;
                  state_nxt   = S_HOLD;
               end
            end
            S_ARG: begin
               operand_nxt = rom_q;
               pc_nxt      = pc + 8'd1;
               state_nxt   = S_HOLD;
            end
            S_HOLD: begin
               if (ir_ready)
                  state_nxt = S_OP;
            end
            default: state_nxt = S_OP;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_OP;
         pc          <= 8'h00;
         ir_op       <= 8'h00;
         ir_operand  <= 8'h00;
         ir_pc       <= 8'h00;
         fetch_count <= 16'h0000;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         ir_op       <= op_nxt;
         ir_operand  <= operand_nxt;
         ir_pc       <= ir_pc_nxt;
         fetch_count <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// The program memory is a 256-byte array that is read combinationally.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clock;
   logic        reset_n;
   logic [7:0]  rom_adrs;
   logic [7:0]  rom_q;
   logic        ir_valid;
   logic        ir_ready;
   logic [7:0]  ir_op;
   logic [7:0]  ir_operand;
   logic [7:0]  ir_pc;
   logic        redirect;
   logic [7:0]  redirect_target;
   logic [15:0] fetch_count;

   logic [7:0]  rom [256];
   int          pass_cnt;
   int          total_cnt;

   assign rom_q = rom[rom_adrs];

   fetch_unit dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .rom_adrs        (rom_adrs),
      .rom_q           (rom_q),
      .ir_valid        (ir_valid),
      .ir_ready        (ir_ready),
      .ir_op           (ir_op),
      .ir_operand      (ir_operand),
      .ir_pc           (ir_pc),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .fetch_count     (fetch_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   // Reset is released mid-cycle, so the next rising edge is the first fetch.
   task automatic do_reset();
      reset_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      logic [48:0] got;
      clear_rom();
      reset_n = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_target = 8'h00;
      step(); step();
      got = {rom_adrs, ir_valid, ir_op, ir_operand, ir_pc, fetch_count};
      total_cnt++;
      if (got !== 49'h0) $display("FAIL reset_state got %h exp %h", got, 49'h0);
      else pass_cnt++;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_two_byte();
      clear_rom();
      rom[8'h00] = 8'h81; rom[8'h01] = 8'h07; rom[8'h02] = 8'h05;
      do_reset();
      step();   // OP -> ARG
      total_cnt++;
      if ({ir_valid, ir_op, rom_adrs} !== {1'b0, 8'h81, 8'h01})
         $display("FAIL two_byte_arg got %h exp %h", {ir_valid, ir_op, rom_adrs}, {1'b0, 8'h81, 8'h01});
      else pass_cnt++;
      step();   // ARG -> HOLD
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc, rom_adrs} !== {1'b1, 8'h81, 8'h07, 8'h00, 8'h02})
         $display("FAIL two_byte_hold got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc, rom_adrs},
                  {1'b1, 8'h81, 8'h07, 8'h00, 8'h02});
      else pass_cnt++;
      ir_ready = 1'b1;
      step();   // accepted
      total_cnt++;
      if ({ir_valid, fetch_count} !== {1'b0, 16'd1})
         $display("FAIL two_byte_accept got %h exp %h", {ir_valid, fetch_count}, {1'b0, 16'd1});
      else pass_cnt++;
      ir_ready = 1'b0;
      step();   // one-byte at 02 must clear the old operand
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc, rom_adrs} !== {1'b1, 8'h05, 8'h00, 8'h02, 8'h03})
         $display("FAIL operand_clear got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc, rom_adrs},
                  {1'b1, 8'h05, 8'h00, 8'h02, 8'h03});
      else pass_cnt++;
   endtask

   task automatic test_hold();
      for (int i = 0; i < 5; i++) begin
         step();
         total_cnt++;
         if ({ir_valid, ir_op, ir_operand, ir_pc, fetch_count, rom_adrs} !==
             {1'b1, 8'h05, 8'h00, 8'h02, 16'd1, 8'h03})
            $display("FAIL hold_stable cycle %0d got %h exp %h", i,
                     {ir_valid, ir_op, ir_operand, ir_pc, fetch_count, rom_adrs},
                     {1'b1, 8'h05, 8'h00, 8'h02, 16'd1, 8'h03});
         else pass_cnt++;
      end
      ir_ready = 1'b1;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count} !== {1'b0, 16'd2})
         $display("FAIL hold_release got %h exp %h", {ir_valid, fetch_count}, {1'b0, 16'd2});
      else pass_cnt++;
      ir_ready = 1'b0;
   endtask

   task automatic test_one_byte();
      clear_rom();
      rom[8'h00] = 8'h01; rom[8'h01] = 8'h06;
      do_reset();
      ir_ready = 1'b1;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc} !== {1'b1, 8'h01, 8'h00, 8'h00})
         $display("FAIL one_byte_first got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc},
                  {1'b1, 8'h01, 8'h00, 8'h00});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count} !== {1'b0, 16'd1})
         $display("FAIL one_byte_cnt1 got %h exp %h", {ir_valid, fetch_count}, {1'b0, 16'd1});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc} !== {1'b1, 8'h06, 8'h00, 8'h01})
         $display("FAIL one_byte_second got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc},
                  {1'b1, 8'h06, 8'h00, 8'h01});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count} !== {1'b0, 16'd2})
         $display("FAIL one_byte_cnt2 got %h exp %h", {ir_valid, fetch_count}, {1'b0, 16'd2});
      else pass_cnt++;
      ir_ready = 1'b0;
   endtask

   task automatic test_redirect_accept();
      clear_rom();
      rom[8'h00] = 8'hC0; rom[8'h01] = 8'h03; rom[8'h03] = 8'h02;
      do_reset();
      step(); step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand} !== {1'b1, 8'hC0, 8'h03})
         $display("FAIL redir_setup got %h exp %h", {ir_valid, ir_op, ir_operand}, {1'b1, 8'hC0, 8'h03});
      else pass_cnt++;
      redirect = 1'b1; redirect_target = 8'h03; ir_ready = 1'b1;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count, rom_adrs} !== {1'b0, 16'd1, 8'h03})
         $display("FAIL redir_accept got %h exp %h", {ir_valid, fetch_count, rom_adrs}, {1'b0, 16'd1, 8'h03});
      else pass_cnt++;
      redirect = 1'b0; ir_ready = 1'b0;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc} !== {1'b1, 8'h02, 8'h00, 8'h03})
         $display("FAIL redir_target_fetch got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc},
                  {1'b1, 8'h02, 8'h00, 8'h03});
      else pass_cnt++;
   endtask

   // Redirect while holding without ready, and while in ARG: no count.
   task automatic test_redirect_no_count();
      rom[8'h10] = 8'h85; rom[8'h11] = 8'h44; rom[8'h20] = 8'h07;
      redirect = 1'b1; redirect_target = 8'h10; ir_ready = 1'b0;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count, rom_adrs} !== {1'b0, 16'd1, 8'h10})
         $display("FAIL redir_hold_noready got %h exp %h", {ir_valid, fetch_count, rom_adrs},
                  {1'b0, 16'd1, 8'h10});
      else pass_cnt++;
      redirect = 1'b0;
      step();   // OP -> ARG on 85
      redirect = 1'b1; redirect_target = 8'h20; ir_ready = 1'b1;
      step();
      total_cnt++;
      if ({ir_valid, fetch_count, rom_adrs} !== {1'b0, 16'd1, 8'h20})
         $display("FAIL redir_in_arg got %h exp %h", {ir_valid, fetch_count, rom_adrs}, {1'b0, 16'd1, 8'h20});
      else pass_cnt++;
      redirect = 1'b0; ir_ready = 1'b0;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc} !== {1'b1, 8'h07, 8'h00, 8'h20})
         $display("FAIL redir_discard got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc},
                  {1'b1, 8'h07, 8'h00, 8'h20});
      else pass_cnt++;
   endtask

   task automatic test_pc_wrap();
      rom[8'hFF] = 8'hDA; rom[8'h00] = 8'h09;
      redirect = 1'b1; redirect_target = 8'hFF;
      step();
      redirect = 1'b0;
      step();   // OP at FF -> ARG, PC wraps
      total_cnt++;
      if ({ir_valid, ir_op, rom_adrs} !== {1'b0, 8'hDA, 8'h00})
         $display("FAIL wrap_arg got %h exp %h", {ir_valid, ir_op, rom_adrs}, {1'b0, 8'hDA, 8'h00});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc, rom_adrs, fetch_count} !==
          {1'b1, 8'hDA, 8'h09, 8'hFF, 8'h01, 16'd1})
         $display("FAIL wrap_hold got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc, rom_adrs, fetch_count},
                  {1'b1, 8'hDA, 8'h09, 8'hFF, 8'h01, 16'd1});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_arg();
      clear_rom();
      rom[8'h00] = 8'h03; rom[8'h30] = 8'h88;
      redirect = 1'b1; redirect_target = 8'h30;
      step();
      redirect = 1'b0;
      step();   // now in ARG
      total_cnt++;
      if ({ir_valid, rom_adrs} !== {1'b0, 8'h31})
         $display("FAIL mid_arg_setup got %h exp %h", {ir_valid, rom_adrs}, {1'b0, 8'h31});
      else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;       // well before the next edge: reset must act asynchronously
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc, rom_adrs, fetch_count} !== 49'h0)
         $display("FAIL async_reset got %h exp %h",
                  {ir_valid, ir_op, ir_operand, ir_pc, rom_adrs, fetch_count}, 49'h0);
      else pass_cnt++;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      step();
      total_cnt++;
      if ({ir_valid, ir_op, ir_operand, ir_pc, fetch_count} !== {1'b1, 8'h03, 8'h00, 8'h00, 16'd0})
         $display("FAIL post_reset_fetch got %h exp %h", {ir_valid, ir_op, ir_operand, ir_pc, fetch_count},
                  {1'b1, 8'h03, 8'h00, 8'h00, 16'd0});
      else pass_cnt++;
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_two_byte();
      test_hold();
      test_one_byte();
      test_redirect_accept();
      test_redirect_no_count();
      test_pc_wrap();
      test_reset_mid_arg();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: rom_adrs  out  8  program-memory byte address; equals internal PC register.
REQ-004 SHALL have port: rom_q  in  8  program-memory read data; combinational from rom_adrs, valid in the same cycle.
REQ-005 SHALL have port: ir_valid  out  1  decoded instruction present on ir_* outputs.
REQ-006 SHALL have port: ir_ready  in  1  execute stage accepts the instruction this cycle.
REQ-007 SHALL have port: ir_op  out  8  opcode byte.
REQ-008 SHALL have port: ir_operand  out  8  second byte; 8'h00 for one-byte instructions.
REQ-009 SHALL have port: ir_pc  out  8  address of the opcode byte.
REQ-010 SHALL have port: redirect  in  1  execute stage requests a jump (taken JMP/JZ).
REQ-011 SHALL have port: redirect_target  in  8  new PC, sampled when redirect=1.
REQ-012 SHALL have port: fetch_count  out  16  number of instructions accepted (ir_valid & ir_ready).

Function
REQ-013 SHALL implement states OP (fetch opcode), ARG (fetch operand), HOLD (present instruction).
REQ-014 In OP: SHALL register rom_q into ir_op and PC into ir_pc, set PC <= PC+1.
REQ-015 In OP: opcode bit7=0 -> SHALL clear ir_operand and go to HOLD; bit7=1 -> SHALL go to ARG.
REQ-016 In ARG: SHALL register rom_q into ir_operand, set PC <= PC+1, go to HOLD.
REQ-017 ir_valid SHALL be 1 exactly while in HOLD (registered state decode, no combinational path from ir_ready).
REQ-018 ir_op, ir_operand, ir_pc SHALL remain stable in HOLD until accepted.
REQ-019 In HOLD with ir_ready=1 and redirect=0: SHALL increment fetch_count and go to OP; PC unchanged.
REQ-020 In HOLD with ir_ready=0: SHALL stay in HOLD, all outputs stable.
REQ-021 redirect=1 in any state SHALL set PC <= redirect_target and state <= OP next cycle, discarding any partially fetched instruction.
REQ-022 redirect=1 with ir_ready=1 in HOLD: instruction counts as accepted (fetch_count +1), then redirect applies.
REQ-023 redirect=1 in OP or ARG, or in HOLD with ir_ready=0: fetch_count SHALL NOT increment.
REQ-024 PC arithmetic SHALL be modulo 256: 8'hFF+1 = 8'h00; a two-byte opcode at 8'hFF takes its operand from 8'h00.
REQ-025 fetch_count SHALL wrap 16'hFFFF -> 16'h0000.
REQ-026 Latency: one-byte instruction valid 1 cycle after entering OP; two-byte 2 cycles; minimum 2 / 3 cycles per instruction at ir_ready=1.
REQ-027 rom_adrs SHALL be driven directly from the PC register (no combinational dependence on inputs).

Reset
REQ-028 reset_n=0 SHALL asynchronously force: PC=8'h00, state=OP, ir_valid=0, ir_op=8'h00, ir_operand=8'h00, ir_pc=8'h00, fetch_count=16'h0000.
REQ-029 Reset asserted mid-instruction (ARG or HOLD) SHALL discard it; first fetch after release SHALL read address 8'h00.
REQ-030 After reset_n deasserts, the first OP fetch SHALL occur on the first rising clock edge.

Verification
REQ-031 ROM {00:01, 01:06}, ir_ready=1 -> ir_valid cycles present (op 01, operand 00, pc 00) then (op 06, pc 01); fetch_count = 2.
REQ-032 ROM {00:81, 01:07}, ir_ready=1 -> single instruction op 81, operand 07, pc 00; next rom_adrs = 02.
REQ-033 Instruction held with ir_ready=0 for 5 cycles -> ir_valid=1 and ir_op/ir_operand/ir_pc unchanged all 5 cycles; fetch_count unchanged.
REQ-034 In HOLD with op C0 operand 03, redirect=1 target 03 with ir_ready=1 -> fetch_count +1, next rom_adrs = 03, state OP.
REQ-035 PC forced to FF via redirect, ROM {FF:DA, 00:09} -> op DA, operand 09, pc FF; next rom_adrs = 01.
REQ-036 reset_n pulsed low during ARG -> ir_valid=0 immediately, no instruction emitted; post-reset first ir_pc = 00.
